// File: rtl/matmul_loader.sv
// Streams two N x N matrices into banked X/Y memories, then hands off to the multiply engine.
// Y is written transposed so each Y bank row holds one column of the original matrix.
module matmul_loader #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAT_DIM_WIDTH = 3,
  parameter int unsigned MAT_DIM_SIZE  = 2 ** MAT_DIM_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic [MAT_DIM_SIZE-1:0]  mat_x_we,
  output logic [MAT_DIM_SIZE-1:0]  mat_y_we,
  output logic [DATA_WIDTH-1:0]    mat_x_w_data,
  output logic [DATA_WIDTH-1:0]    mat_y_w_data,
  output logic [MAT_DIM_WIDTH-1:0] mat_x_w_addr,
  output logic [MAT_DIM_WIDTH-1:0] mat_y_w_addr,
  output logic                     start,
  input  logic                     calculation_done,
  output logic                     busy,
  output logic                     run_done
);

  localparam int unsigned CntWidth = 2 * MAT_DIM_WIDTH;
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(MAT_DIM_SIZE * MAT_DIM_SIZE - 1);
  localparam logic [MAT_DIM_SIZE-1:0] OneHot0 = MAT_DIM_SIZE'(1);

  typedef enum logic [1:0] {
    StLoadX,
    StLoadY,
    StStart,
    StBusy
  } state_e;

  state_e                   state_q;
  logic [CntWidth-1:0]      cnt_q;
  logic                     calc_done_q;
  logic                     run_done_q;
  logic [MAT_DIM_SIZE-1:0]  x_we_q;
  logic [MAT_DIM_SIZE-1:0]  y_we_q;
  logic [DATA_WIDTH-1:0]    x_data_q;
  logic [DATA_WIDTH-1:0]    y_data_q;
  logic [MAT_DIM_WIDTH-1:0] x_addr_q;
  logic [MAT_DIM_WIDTH-1:0] y_addr_q;

  logic                     accept;
  logic                     last_beat;
  logic                     done_rise;
  logic [MAT_DIM_WIDTH-1:0] row;
  logic [MAT_DIM_WIDTH-1:0] col;
  logic [MAT_DIM_SIZE-1:0]  row_oh;
  logic [MAT_DIM_SIZE-1:0]  col_oh;
  logic [CntWidth-1:0]      cnt_d;

  always_comb begin
    row       = cnt_q[CntWidth-1:MAT_DIM_WIDTH];
    col       = cnt_q[MAT_DIM_WIDTH-1:0];
    row_oh    = OneHot0 << row;
    col_oh    = OneHot0 << col;
    accept    = in_valid && in_ready;
    last_beat = (cnt_q == LastBeat);
    // Counter restarts at 0 after the final beat of each matrix.
    cnt_d     = last_beat ? '0 : cnt_q + 1'b1;
    done_rise = calculation_done && !calc_done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoadX;
      cnt_q       <= '0;
      calc_done_q <= 1'b0;
      run_done_q  <= 1'b0;
      x_we_q      <= '0;
      y_we_q      <= '0;
      x_data_q    <= '0;
      y_data_q    <= '0;
      x_addr_q    <= '0;
      y_addr_q    <= '0;
    end else begin
      calc_done_q <= calculation_done;
      run_done_q  <= 1'b0;
      x_we_q      <= '0;
      y_we_q      <= '0;
      unique case (state_q)
        StLoadX: begin
          if (accept) begin
            x_we_q   <= col_oh;
            x_addr_q <= row;
            x_data_q <= in_data;
            cnt_q    <= cnt_d;
            if (last_beat) state_q <= StLoadY;
          end
        end
        StLoadY: begin
          if (accept) begin
            y_we_q   <= row_oh;
            y_addr_q <= col;
            y_data_q <= in_data;
            cnt_q    <= cnt_d;
            if (last_beat) state_q <= StStart;
          end
        end
        StStart: begin
          state_q <= StBusy;
        end
        StBusy: begin
          // Only a fresh low-to-high edge ends the run; a stale high level is ignored.
          if (done_rise) begin
            run_done_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StLoadX;
          end
        end
        default: begin
          state_q <= StLoadX;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign in_ready     = (state_q == StLoadX) || (state_q == StLoadY);
  assign busy         = (state_q == StStart) || (state_q == StBusy);
  assign start        = (state_q == StStart);
  assign run_done     = run_done_q;
  assign mat_x_we     = x_we_q;
  assign mat_y_we     = y_we_q;
  assign mat_x_w_data = x_data_q;
  assign mat_y_w_data = y_data_q;
  assign mat_x_w_addr = x_addr_q;
  assign mat_y_w_addr = y_addr_q;

endmodule

// File: tb/tb_matmul_loader.sv
// Directed bench for matmul_loader: full loads, random stalls, stale done level, mid-load reset.
module tb_matmul_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned W  = 3;
  localparam int unsigned N  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [N-1:0]  mat_x_we;
  logic [N-1:0]  mat_y_we;
  logic [DW-1:0] mat_x_w_data;
  logic [DW-1:0] mat_y_w_data;
  logic [W-1:0]  mat_x_w_addr;
  logic [W-1:0]  mat_y_w_addr;
  logic          start;
  logic          calculation_done;
  logic          busy;
  logic          run_done;

  matmul_loader #(
    .DATA_WIDTH   (DW),
    .MAT_DIM_WIDTH(W),
    .MAT_DIM_SIZE (N)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .mat_x_we        (mat_x_we),
    .mat_y_we        (mat_y_we),
    .mat_x_w_data    (mat_x_w_data),
    .mat_y_w_data    (mat_y_w_data),
    .mat_x_w_addr    (mat_x_w_addr),
    .mat_y_w_addr    (mat_y_w_addr),
    .start           (start),
    .calculation_done(calculation_done),
    .busy            (busy),
    .run_done        (run_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected-write model, filled in by send() before the accepting edge.
  bit            exp_x, exp_y;
  logic [N-1:0]  exp_xwe, exp_ywe;
  logic [W-1:0]  exp_xa, exp_ya;
  logic [DW-1:0] exp_xd, exp_yd;
  int            mk = 0;
  int            x_wr = 0, y_wr = 0, start_cnt = 0, done_cnt = 0;
  int            seen_x[64];
  int            seen_y[64];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and compare write outputs against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_x) begin
      check("x_we", 64'(mat_x_we), 64'(exp_xwe));
      check("x_addr", 64'(mat_x_w_addr), 64'(exp_xa));
      check("x_data", 64'(mat_x_w_data), 64'(exp_xd));
    end else begin
      check("x_we_idle", 64'(mat_x_we), 64'(0));
    end
    if (exp_y) begin
      check("y_we", 64'(mat_y_we), 64'(exp_ywe));
      check("y_addr", 64'(mat_y_w_addr), 64'(exp_ya));
      check("y_data", 64'(mat_y_w_data), 64'(exp_yd));
    end else begin
      check("y_we_idle", 64'(mat_y_we), 64'(0));
    end
    exp_x = 1'b0;
    exp_y = 1'b0;
    if (mat_x_we != '0) begin
      x_wr++;
      for (int i = 0; i < int'(N); i++) if (mat_x_we[i]) seen_x[int'(mat_x_w_addr) * 8 + i]++;
    end
    if (mat_y_we != '0) begin
      y_wr++;
      for (int i = 0; i < int'(N); i++) if (mat_y_we[i]) seen_y[i * 8 + int'(mat_y_w_addr)]++;
    end
    if (start) begin
      check("start_after_done", 64'(start_cnt), 64'(done_cnt));
      start_cnt++;
    end
    if (run_done) done_cnt++;
  endtask

  task automatic send(input logic [DW-1:0] d, input int gap);
    int t;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    check("ready_timeout", 64'(t < 50), 64'(1));
    if (mk < 64) begin
      exp_x   = 1'b1;
      exp_xwe = N'(1) << (mk % 8);
      exp_xa  = W'(mk / 8);
      exp_xd  = d;
    end else begin
      exp_y   = 1'b1;
      exp_ywe = N'(1) << ((mk - 64) / 8);
      exp_ya  = W'((mk - 64) % 8);
      exp_yd  = d;
    end
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    mk = (mk + 1) % 128;
  endtask

  task automatic load(input int nbeats, input bit rand_gap, input bit hold_calc);
    for (int k = 0; k < nbeats; k++) begin
      if (hold_calc && k == 120) calculation_done = 1'b1;
      send(DW'(k), rand_gap ? int'($urandom_range(0, 1)) : 0);
      if (k < 64) check("x_in_ready", 64'(in_ready), 64'(1));
      if (k == 10) begin
        check("x10_we", 64'(mat_x_we), 64'h04);
        check("x10_addr", 64'(mat_x_w_addr), 64'd1);
      end
      if (k == 74) begin
        check("y10_we", 64'(mat_y_we), 64'h02);
        check("y10_addr", 64'(mat_y_w_addr), 64'd2);
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_start", 64'(start), 64'(0));
    check("rst_run_done", 64'(run_done), 64'(0));
    check("rst_x_addr", 64'(mat_x_w_addr), 64'(0));
    check("rst_y_addr", 64'(mat_y_w_addr), 64'(0));
    check("rst_x_data", 64'(mat_x_w_data), 64'(0));
    check("rst_y_data", 64'(mat_y_w_data), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    int ok;
    bit got;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    calculation_done = 1'b0;
    exp_x = 1'b0;
    exp_y = 1'b0;
    for (int i = 0; i < 64; i++) begin
      seen_x[i] = 0;
      seen_y[i] = 0;
    end
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs();

    // Run A: sequential load, done held high from late Y load through BUSY entry.
    load(128, 1'b0, 1'b1);
    check("a_start", 64'(start), 64'(1));
    check("a_busy", 64'(busy), 64'(1));
    check("a_in_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (5) begin
      tick();
      check("a_start_once", 64'(start), 64'(0));
      check("a_busy_hold", 64'(busy), 64'(1));
      check("a_ready_hold", 64'(in_ready), 64'(0));
      check("a_no_stale_done", 64'(run_done), 64'(0));
    end
    in_valid = 1'b0;
    calculation_done = 1'b0;
    tick();
    tick();
    check("a_low_no_done", 64'(run_done), 64'(0));
    calculation_done = 1'b1;
    tick();
    check("a_run_done", 64'(run_done), 64'(1));
    check("a_busy_clear", 64'(busy), 64'(0));
    check("a_ready_back", 64'(in_ready), 64'(1));
    calculation_done = 1'b0;
    tick();
    check("a_run_done_pulse", 64'(run_done), 64'(0));
    check("a_done_count", 64'(done_cnt), 64'(1));

    // Run B: back-to-back with random stalls, same data as run A.
    x_wr = 0;
    y_wr = 0;
    for (int i = 0; i < 64; i++) begin
      seen_x[i] = 0;
      seen_y[i] = 0;
    end
    load(128, 1'b1, 1'b0);
    check("b_start", 64'(start), 64'(1));
    check("b_x_writes", 64'(x_wr), 64'd64);
    check("b_y_writes", 64'(y_wr), 64'd64);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (seen_x[i] == 1) ok++;
      if (seen_y[i] == 1) ok++;
    end
    check("b_unique_cells", 64'(ok), 64'd128);
    tick();
    tick();
    tick();
    calculation_done = 1'b1;
    got = 1'b0;
    t = 0;
    while (!got && t < 10) begin
      tick();
      if (run_done) got = 1'b1;
      t++;
    end
    check("b_run_done", 64'(got), 64'(1));
    calculation_done = 1'b0;
    check("b_ready_back", 64'(in_ready), 64'(1));
    check("b_start_count", 64'(start_cnt), 64'd2);

    // Run C: reset after 30 Y beats, then the next beat must land at X (0,0).
    load(94, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs();
    mk = 0;
    send(32'hABCD_1234, 0);
    check("c_x_we", 64'(mat_x_we), 64'h01);
    check("c_x_addr", 64'(mat_x_w_addr), 64'd0);
    check("c_x_data", 64'(mat_x_w_data), 64'hABCD_1234);
    check("c_y_we", 64'(mat_y_we), 64'(0));
    tick();
    check("c_done_count", 64'(done_cnt), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matmul_loader.md
MATMUL_LOADER -- requirements
Module: matmul_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of one matrix element.
REQ-002 The block SHALL have parameter MAT_DIM_WIDTH, default 3, log2 of the matrix dimension.
REQ-003 The block SHALL have parameter MAT_DIM_SIZE, default 2**MAT_DIM_WIDTH, matrix dimension N and bank count.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit, upstream element valid.
REQ-007 The block SHALL have port in_data, input, DATA_WIDTH bits, upstream element value.
REQ-008 The block SHALL have port in_ready, output, 1 bit, element accepted when in_valid and in_ready are both high.
REQ-009 The block SHALL have port mat_x_we, output, MAT_DIM_SIZE bits, one-hot bank write enable, X matrix.
REQ-010 The block SHALL have port mat_y_we, output, MAT_DIM_SIZE bits, one-hot bank write enable, Y matrix.
REQ-011 The block SHALL have ports mat_x_w_data and mat_y_w_data, outputs, DATA_WIDTH bits each, write data.
REQ-012 The block SHALL have ports mat_x_w_addr and mat_y_w_addr, outputs, MAT_DIM_WIDTH bits each, bank row address.
REQ-013 The block SHALL have port start, output, 1 bit, one-cycle pulse launching the multiply engine.
REQ-014 The block SHALL have port calculation_done, input, 1 bit, completion indication from the engine.
REQ-015 The block SHALL have port busy, output, 1 bit, high while not accepting elements.
REQ-016 The block SHALL have port run_done, output, 1 bit, one-cycle pulse on engine completion.

Function
REQ-017 The input stream SHALL be N*N X elements, then N*N Y elements, each in row-major order; beat index k gives row r=k/N and column c=k%N.
REQ-018 An accepted X element (r,c) SHALL produce mat_x_w_addr=r, mat_x_we bit c set, and mat_x_w_data=in_data.
REQ-019 An accepted Y element (r,c) SHALL produce mat_y_w_addr=c, mat_y_we bit r set, and mat_y_w_data=in_data (transposed so that a column read returns column c).
REQ-020 Write outputs SHALL be registered: a beat accepted in cycle T drives exactly one write-enable bit high in cycle T+1 only, and all enable bits are zero otherwise.
REQ-021 The FSM SHALL have states LOAD_X, LOAD_Y, START, BUSY; in_ready=1 only in LOAD_X and LOAD_Y; busy=1 only in START and BUSY.
REQ-022 In LOAD_X, acceptance of beat N*N-1 SHALL move the FSM to LOAD_Y with the element counter reset to 0.
REQ-023 In LOAD_Y, acceptance of beat N*N-1 SHALL move the FSM to START.
REQ-024 The counter SHALL advance only on accepted beats; in_valid low stalls indefinitely with no writes.
REQ-025 In START the block SHALL assert start for exactly one cycle (cycle T+1 after the last Y beat at T, coincident with the last Y write) and then enter BUSY.
REQ-026 The block SHALL register calculation_done every cycle; in BUSY, a rising edge (registered value 0, current value 1) SHALL pulse run_done for one cycle and return the FSM to LOAD_X with the counter at 0.
REQ-027 A calculation_done level that is already high on entry to BUSY SHALL NOT end BUSY; the block SHALL wait for low followed by high.
REQ-028 in_data SHALL be ignored when no beat is accepted, and in_valid while busy=1 SHALL be held off, not dropped.

Reset
REQ-029 When rst=1 at a clock edge, the FSM SHALL go to LOAD_X, the counter to 0, in_ready to 1, and every other output (start, busy, run_done, all write enables, addresses, data) to 0.
REQ-030 A reset in the middle of a load or a run SHALL abandon it; memory contents are not cleared, and the next load SHALL begin again at X element (0,0).

Verification
REQ-031 A bench SHALL check: reset, then 64 X beats with values 0..63 -> X beat k=10 writes addr 1 with we 8'b0000_0100, and in_ready stays 1.
REQ-032 A bench SHALL check: 64 Y beats after X -> Y beat k=10 writes mat_y_w_addr=2 with mat_y_we=8'b0000_0010; start pulses one cycle, then busy=1 and in_ready=0.
REQ-033 A bench SHALL check: in_valid toggled randomly (about 50%) during the load -> exactly 128 writes and no duplicated or skipped addresses.
REQ-034 A bench SHALL check: calculation_done held high through START and BUSY entry, then dropped and raised -> run_done pulses once, only after the rise.
REQ-035 A bench SHALL check: rst asserted after 30 Y beats -> outputs return to reset values, and the next beat is treated as X (0,0) with mat_x_we=8'b0000_0001 and addr 0.
REQ-036 A bench SHALL check: two back-to-back full runs -> second start pulse only after the first run_done, with identical write sequences.
